// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the framed serial transmitter: state encoding,
// idle line level and the counter-width helper.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Width needed to hold the values 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_period_counter.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each period.
module bit_period_counter
  import serial_frame_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = cntWidth(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Restart the period on Clear so a new frame begins phase-aligned.
  always_comb begin
    count_d = count_q + CW'(1);
    if (Clear || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Tick = (count_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB first,
// stop bit, each bit lasting DIV clock cycles. All outputs are registered.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Sout,
  output logic             Busy,
  output logic             Done
);

  localparam int BW = cntWidth(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bitCnt_q, bitCnt_d;
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clear;
  logic             tick;

  bit_period_counter #(.DIV(DIV)) u_bitPeriod (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (clear),
    .Tick  (tick)
  );

  // Frame sequencing; output levels are derived from the next state so they land in registers.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    clear    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d  = START;
          shift_d  = D;
          bitCnt_d = '0;
          clear    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bitCnt_q == LAST_BIT) begin
            state_d  = STOP;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   sout_d = ~LINE_IDLE;
      DATA:    sout_d = shift_d[0];
      default: sout_d = LINE_IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // State, datapath and output registers; reset abandons any frame at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      sout_q   <= LINE_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      sout_q   <= sout_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Sout  = sout_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: an 8-bit/DIV=4 instance and a
// 4-bit/DIV=1 instance driven with directed and random frames.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [7:0] dA;
  logic       loadA;
  logic       readyA, soutA, busyA, doneA;

  logic [3:0] dB;
  logic       loadB;
  logic       readyB, soutB, busyB, doneB;

  int assertCount = 0;
  int failCount   = 0;

  serial_frame_tx #(.WIDTH(8), .DIV(4)) dutA (
    .Clk(clk), .Reset(rst), .D(dA), .Load(loadA),
    .Ready(readyA), .Sout(soutA), .Busy(busyA), .Done(doneA)
  );

  serial_frame_tx #(.WIDTH(4), .DIV(1)) dutB (
    .Clk(clk), .Reset(rst), .D(dB), .Load(loadB),
    .Ready(readyB), .Sout(soutB), .Busy(busyB), .Done(doneB)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Expected line level in frame cycle k (1-based) for word d.
  function automatic logic lineAt(input int k, input logic [31:0] d, input int w, input int div);
    int p;
    p = (k - 1) / div;
    if (p == 0) return 1'b0;
    if (p <= w) return d[p-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkA(input string tag, input logic s, input logic r, input logic b, input logic dn);
    checkOutput({tag, ".sout"},  soutA,  s);
    checkOutput({tag, ".ready"}, readyA, r);
    checkOutput({tag, ".busy"},  busyA,  b);
    checkOutput({tag, ".done"},  doneA,  dn);
  endtask

  task automatic checkB(input string tag, input logic s, input logic r, input logic b, input logic dn);
    checkOutput({tag, ".soutB"},  soutB,  s);
    checkOutput({tag, ".readyB"}, readyB, r);
    checkOutput({tag, ".busyB"},  busyB,  b);
    checkOutput({tag, ".doneB"},  doneB,  dn);
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] d);
    loadA = l;
    dA    = d;
  endtask

  // Idle cycles on instance A with Load low.
  task automatic idleA(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkA($sformatf("idle%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'($urandom));
    end
  endtask

  // Follows one frame on instance A; the accepting Load must already be driven.
  task automatic runFrameA(input logic [7:0] d, input bit holdLoad, input int pokeAt,
                           input int abortAt, input bit loadAfter, input logic [7:0] dAfter);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 41) checkA($sformatf("done d=%h", d), 1'b1, 1'b1, 1'b0, 1'b1);
      else checkA($sformatf("frame d=%h k=%0d", d, k), lineAt(k, 32'(d), 8, 4), 1'b0, 1'b1, 1'b0);
      if (k == abortAt) return;
      if (k == 41) applyStimulus(loadAfter, dAfter);
      else if (holdLoad || k == pokeAt) applyStimulus(1'b1, (k == pokeAt) ? 8'h3C : 8'($urandom));
      else applyStimulus(1'b0, 8'($urandom));
    end
  endtask

  // Follows one frame on the DIV=1 instance.
  task automatic runFrameB(input logic [3:0] d, input bit loadAfter, input logic [3:0] dAfter);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 7) checkB($sformatf("doneB d=%h", d), 1'b1, 1'b1, 1'b0, 1'b1);
      else checkB($sformatf("frameB d=%h k=%0d", d, k), lineAt(k, 32'(d), 4, 1), 1'b0, 1'b1, 1'b0);
      if (k == 7) begin
        loadB = loadAfter;
        dB    = dAfter;
      end else begin
        loadB = 1'b0;
        dB    = 4'($urandom);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] db;
    logic [5:0] seqB;
    applyStimulus(1'b0, 8'h00);
    loadB = 1'b0;
    dB    = 4'h0;

    #1 rst = 1'b1;
    #1;
    checkA("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    checkB("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle after reset");
    idleA(20);

    $display("[TB] single frame A5");
    applyStimulus(1'b1, 8'hA5);
    runFrameA(8'hA5, 1'b0, 0, 0, 1'b0, 8'h00);
    idleA(3);

    $display("[TB] back-to-back frames with Load held");
    applyStimulus(1'b1, 8'h00);
    runFrameA(8'h00, 1'b1, 0, 0, 1'b1, 8'hFF);
    runFrameA(8'hFF, 1'b1, 0, 0, 1'b0, 8'h00);
    idleA(3);

    $display("[TB] Load during data bit 3 ignored");
    applyStimulus(1'b1, 8'h5A);
    runFrameA(8'h5A, 1'b0, 18, 0, 1'b0, 8'h00);
    idleA(5);

    $display("[TB] asynchronous reset during data bit 5");
    d = 8'($urandom);
    applyStimulus(1'b1, d);
    runFrameA(d, 1'b0, 0, 26, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkA("asyncReset", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkA("heldReset", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    idleA(2);
    d = 8'($urandom);
    applyStimulus(1'b1, d);
    runFrameA(d, 1'b0, 0, 0, 1'b0, 8'h00);
    idleA(2);

    $display("[TB] random frames");
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      applyStimulus(1'b1, d);
      runFrameA(d, 1'b0, 0, 0, 1'b0, 8'h00);
      idleA($urandom_range(1, 3));
    end

    $display("[TB] DIV=1 WIDTH=4 frame 0110");
    @(negedge clk);
    checkB("idleB", 1'b1, 1'b1, 1'b0, 1'b0);
    loadB = 1'b1;
    dB    = 4'b0110;
    seqB  = 6'b101100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 7) begin
        checkB("literalDoneB", 1'b1, 1'b1, 1'b0, 1'b1);
      end else begin
        checkOutput($sformatf("literalSoutB k=%0d", k), soutB, seqB[k-1]);
        checkOutput($sformatf("literalBusyB k=%0d", k), busyB, 1'b1);
      end
      loadB = 1'b0;
      dB    = 4'($urandom);
    end

    $display("[TB] DIV=1 random back-to-back frames");
    db    = 4'($urandom);
    loadB = 1'b1;
    dB    = db;
    for (int n = 0; n < 4; n++) begin
      logic [3:0] nextD;
      nextD = 4'($urandom);
      runFrameB(db, (n < 3), nextD);
      db = nextD;
    end
    @(negedge clk);
    checkB("idleAfterB", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
